// File: rtl/sreg_universal_if.sv
// Bus bundle for the universal shift register.
// The master drives the control and data inputs and reads back the register state.
interface sreg_universal_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             en;
   logic [1:0]       mode;
   logic             rot;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] pin;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    cnt;
   logic             done;

   modport master (
      output en, mode, rot, sin_r, sin_l, pin,
      input  q, sout_r, sout_l, cnt, done
   );

   modport slave (
      input  en, mode, rot, sin_r, sin_l, pin,
      output q, sout_r, sout_l, cnt, done
   );
endinterface

// File: rtl/sreg_universal.sv
// Universal shift register: hold, shift right, shift left or parallel load.
// Shifts either rotate or take a serial input. A saturating counter tracks
// the shifts since the last load or reset, and done pulses for one cycle
// when a full frame of WIDTH shifts completes.
module sreg_universal #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input logic             sys_clk,
   input logic             sys_rst,
   sreg_universal_if.slave bus
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_p0;
   logic [CW-1:0]    cnt_p0;
   logic             done_p0;

   // Right shift: the fill bit enters at the MSB.
   function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                    input logic             fill);
      return {fill, v[WIDTH-1:1]};
   endfunction

   // Left shift: the fill bit enters at the LSB.
   function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                   input logic             fill);
      return {v[WIDTH-2:0], fill};
   endfunction

   // Saturating shift counter; it never wraps back to zero.
   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
      return (c == CNT_FULL) ? c : c + CW'(1);
   endfunction

   // Register, counter and frame pulse. Reset wins over enable, and enable wins over mode.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         q_p0    <= '0;
         cnt_p0  <= '0;
         done_p0 <= 1'b0;
      end else if (!bus.en) begin
         done_p0 <= 1'b0;
      end else begin
         case (bus.mode)
            MODE_RIGHT: begin
               q_p0    <= shift_right(q_p0, bus.rot ? q_p0[0] : bus.sin_r);
               cnt_p0  <= cnt_inc(cnt_p0);
               done_p0 <= (cnt_p0 == CNT_LAST);
            end
            MODE_LEFT: begin
               q_p0    <= shift_left(q_p0, bus.rot ? q_p0[WIDTH-1] : bus.sin_l);
               cnt_p0  <= cnt_inc(cnt_p0);
               done_p0 <= (cnt_p0 == CNT_LAST);
            end
            MODE_LOAD: begin
               q_p0    <= bus.pin;
               cnt_p0  <= '0;
               done_p0 <= 1'b0;
            end
            MODE_HOLD: begin
               done_p0 <= 1'b0;
            end
            default: begin
               done_p0 <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q      = q_p0;
   assign bus.cnt    = cnt_p0;
   assign bus.done   = done_p0;
   // The serial outputs are taken straight from the end bits of the register.
   assign bus.sout_r = q_p0[0];
   assign bus.sout_l = q_p0[WIDTH-1];

endmodule

// File: tb/tb_sreg_universal.sv
// Testbench for sreg_universal (WIDTH=8): directed frame scenarios plus
// randomized traffic, checked against an arithmetic reference model.
module tb_sreg_universal;

   localparam int W = 8;
   localparam longint unsigned MASK = (64'd1 << W) - 1;

   logic sys_clk;
   logic sys_rst;

   sreg_universal_if #(.WIDTH(W)) bus ();

   sreg_universal #(.WIDTH(W)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference model state.
   longint unsigned mq;
   int              mcnt;
   bit              mdone;

   int n_chk;
   int n_fail;
   int ndone;

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, and compare all outputs after the edge.
   task automatic step(input bit r, input bit e, input bit [1:0] m, input bit ro,
                       input bit sr, input bit sl, input bit [W-1:0] p);
      longint unsigned fill;
      sys_rst   = r;
      bus.en    = e;
      bus.mode  = m;
      bus.rot   = ro;
      bus.sin_r = sr;
      bus.sin_l = sl;
      bus.pin   = p;
      @(posedge sys_clk);
      if (r) begin
         mq = 0; mcnt = 0; mdone = 0;
      end else if (!e || m == 2'd0) begin
         mdone = 0;
      end else if (m == 2'd3) begin
         mq = p; mcnt = 0; mdone = 0;
      end else begin
         if (m == 2'd1) begin
            fill = ro ? (mq & 1) : longint'(sr);
            mq   = (mq >> 1) | (fill << (W - 1));
         end else begin
            fill = ro ? ((mq >> (W - 1)) & 1) : longint'(sl);
            mq   = ((mq << 1) | fill) & MASK;
         end
         mdone = (mcnt == W - 1);
         if (mcnt < W) mcnt++;
      end
      #1;
      chk("model_q",      bus.q,      mq);
      chk("model_cnt",    bus.cnt,    mcnt);
      chk("model_done",   bus.done,   mdone);
      chk("model_sout_r", bus.sout_r, mq & 1);
      chk("model_sout_l", bus.sout_l, (mq >> (W - 1)) & 1);
      if (bus.done) ndone++;
   endtask

   initial begin
      bit          hist[$];
      bit          b;
      bit [W-1:0]  a5;
      n_chk = 0; n_fail = 0; ndone = 0;
      mq = 0; mcnt = 0; mdone = 0;
      sys_rst = 1'b1;
      bus.en = 1'b0; bus.mode = 2'd0; bus.rot = 1'b0;
      bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.pin = '0;

      // Reset for two cycles with random controls.
      for (int i = 0; i < 2; i++) begin
         step(1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
         chk("rst_q", bus.q, 0);
         chk("rst_cnt", bus.cnt, 0);
         chk("rst_done", bus.done, 0);
         chk("rst_sout_r", bus.sout_r, 0);
         chk("rst_sout_l", bus.sout_l, 0);
      end

      // Load 0xA5 and shift it out to the right.
      a5 = 8'hA5;
      step(0, 1, 2'd3, 0, 0, 0, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         chk("a5_sout_r", bus.sout_r, a5[i]);
         step(0, 1, 2'd1, 0, 0, 1'($urandom), W'($urandom));
         chk("a5_done", bus.done, (i == 7) ? 1 : 0);
      end
      chk("a5_q", bus.q, 8'h00);
      chk("a5_cnt", bus.cnt, 8);

      // Rotate left then right.
      step(0, 1, 2'd3, 0, 0, 0, 8'h81);
      step(0, 1, 2'd2, 1, 1'($urandom), 1'($urandom), W'($urandom));
      chk("rot_l_q", bus.q, 8'h03);
      step(0, 1, 2'd1, 1, 1'($urandom), 1'($urandom), W'($urandom));
      chk("rot_r_q", bus.q, 8'h81);
      chk("rot_cnt", bus.cnt, 2);
      chk("rot_done", bus.done, 0);

      // Frame interrupted by an enable gap.
      step(0, 1, 2'd3, 0, 0, 0, 8'hF0);
      ndone = 0;
      for (int i = 0; i < 3; i++) step(0, 1, 2'd2, 0, 1'($urandom), 0, W'($urandom));
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
         chk("hold_q", bus.q, 8'h80);
         chk("hold_cnt", bus.cnt, 3);
         chk("hold_done", bus.done, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 2'd2, 0, 1'($urandom), 1, W'($urandom));
      chk("gap_q", bus.q, 8'h1F);
      chk("gap_cnt", bus.cnt, 8);
      chk("gap_pulses", ndone, 1);

      // Reset mid-frame abandons the frame.
      step(0, 1, 2'd3, 0, 0, 0, 8'hFF);
      for (int i = 0; i < 5; i++) step(0, 1, 2'd1, 0, 1'($urandom), 1'($urandom), W'($urandom));
      step(1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
      chk("midrst_q", bus.q, 0);
      ndone = 0;
      for (int i = 0; i < 7; i++) step(0, 1, 2'd1, 0, 1'($urandom), 1'($urandom), W'($urandom));
      chk("midrst_cnt", bus.cnt, 7);
      chk("midrst_nodone", ndone, 0);
      step(0, 1, 2'd1, 0, 1'($urandom), 1'($urandom), W'($urandom));
      chk("midrst_done8", bus.done, 1);

      // Serial in, serial out on the left side.
      step(0, 1, 2'd3, 0, 0, 0, 8'h00);
      ndone = 0;
      for (int n = 1; n <= 24; n++) begin
         b = 1'($urandom);
         hist.push_back(b);
         step(0, 1, 2'd2, 0, 1'($urandom), b, W'($urandom));
         if (n >= W) chk("siso_sout_l", bus.sout_l, hist[n - W]);
      end
      chk("siso_cnt", bus.cnt, 8);
      chk("siso_pulses", ndone, 1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
